pocket_arbiter: RTL

Detects balls falling into the table holes and reports each pocketing event, one at a time, to game/score logic over a valid/ack handshake. It sits between the per-pixel drawing requests (the ball objects and the combined hole objects) and the game controller. It accumulates ball/hole pixel overlap over each VGA frame and qualifies hits at frame boundaries. Qualified hits are shared fairly through a round-robin arbiter, and the block tracks which balls are off the table.

---
 rtl/pocket_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pocket_arbiter.sv
// Pocketing detector: accumulates ball/hole overlap per frame, qualifies hits at frame start,
// and hands pocketing events one at a time to the game logic through a round-robin valid/ack arbiter.
module pocket_arbiter #(
   parameter int NUM_BALLS   = 16,
   parameter int ID_W        = 4,
   parameter int MIN_OVERLAP = 4
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic [NUM_BALLS-1:0] ballDrawingRequest,
   input  logic                 holeDrawingRequest,
   input  logic                 newRack,
   input  logic                 pocket_ack,
   output logic                 pocket_valid,
   output logic [ID_W-1:0]      pocket_id,
   output logic                 cue_scratch,
   output logic [NUM_BALLS-1:0] pocketed_mask,
   output logic [4:0]           balls_left,
   output logic                 all_pocketed
);

   localparam logic [2:0]     OVL_MAX = 3'd7;
   localparam logic [2:0]     OVL_MIN = 3'(MIN_OVERLAP);
   localparam logic [ID_W:0]  NUM_W   = (ID_W+1)'(NUM_BALLS);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_BALLS-1);
   localparam logic [ID_W-1:0] ONE_ID  = ID_W'(1);

   typedef enum logic {IDLE, OFFER} arbStateT;

   arbStateT                   stateReg;
   logic [NUM_BALLS-1:0][2:0]  ovlReg;
   logic [NUM_BALLS-1:0][2:0]  ovlNext;
   logic [NUM_BALLS-1:0]       pendingReg;
   logic [NUM_BALLS-1:0]       pendingNext;
   logic [NUM_BALLS-1:0]       overlapHit;
   logic [NUM_BALLS-1:0]       qualify;
   logic [NUM_BALLS-1:0]       ackHit;
   logic [ID_W-1:0]            rrPtrReg;
   logic                       offerAck;
   logic                       selFound;
   logic [ID_W-1:0]            selIdx;
   logic [ID_W:0]              cand;
   logic [4:0]                 leftCount;

   assign offerAck = (stateReg == OFFER) && pocket_ack;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_BALLS; gi++) begin : gBall
         assign overlapHit[gi] = ballDrawingRequest[gi] & holeDrawingRequest & ~pocketed_mask[gi];
         assign qualify[gi]    = (ovlReg[gi] >= OVL_MIN) & ~pocketed_mask[gi];
         assign ackHit[gi]     = offerAck && (pocket_id == ID_W'(gi));

         // The frame-start pixel already belongs to the new frame, so it seeds the counter.
         assign ovlNext[gi] = startOfFrame ? {2'b00, overlapHit[gi]} :
                              (overlapHit[gi] && (ovlReg[gi] != OVL_MAX)) ? ovlReg[gi] + 3'd1 :
                              ovlReg[gi];

         // An ack on the same edge wins over a fresh qualification of that ball.
         assign pendingNext[gi] = ~ackHit[gi] & (pendingReg[gi] | (startOfFrame & qualify[gi]));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!resetN || newRack) begin
         ovlReg     <= '0;
         pendingReg <= '0;
      end else begin
         ovlReg     <= ovlNext;
         pendingReg <= pendingNext;
      end
   end

   // First pending ball at or after the round-robin pointer, wrapping modulo NUM_BALLS.
   always_comb begin
      selFound = 1'b0;
      selIdx   = '0;
      cand     = '0;
      for (int k = 0; k < NUM_BALLS; k++) begin
         cand = {1'b0, rrPtrReg} + (ID_W+1)'(k);
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (!selFound && pendingReg[cand[ID_W-1:0]]) begin
            selFound = 1'b1;
            selIdx   = cand[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         stateReg      <= IDLE;
         pocket_valid  <= 1'b0;
         pocket_id     <= '0;
         cue_scratch   <= 1'b0;
         pocketed_mask <= '0;
         rrPtrReg      <= '0;
      end else if (newRack) begin
         stateReg      <= IDLE;
         pocket_valid  <= 1'b0;
         cue_scratch   <= 1'b0;
         pocketed_mask <= '0;
         rrPtrReg      <= '0;
      end else begin
         cue_scratch <= 1'b0;
         case (stateReg)
            IDLE: begin
               if (selFound) begin
                  pocket_id    <= selIdx;
                  pocket_valid <= 1'b1;
                  stateReg     <= OFFER;
               end
            end
            OFFER: begin
               if (pocket_ack) begin
                  pocket_valid <= 1'b0;
                  stateReg     <= IDLE;
                  rrPtrReg     <= (pocket_id == LAST_ID) ? '0 : pocket_id + ONE_ID;
                  // The cue ball respawns, so it only raises a scratch pulse.
                  if (pocket_id == '0) begin
                     cue_scratch <= 1'b1;
                  end else begin
                     pocketed_mask <= pocketed_mask | ackHit;
                  end
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   always_comb begin
      leftCount = 5'(NUM_BALLS-1);
      for (int i = 1; i < NUM_BALLS; i++) begin
         leftCount = leftCount - 5'(pocketed_mask[i]);
      end
   end

   assign balls_left   = leftCount;
   assign all_pocketed = (leftCount == 5'd0);

endmodule
